ice_tx: RTL and testbench

Transmit side of the in-circuit-emulator (ICE) serial link. Takes a 16-bit word (the ICE address or data register, e.g. the PC captured by an ICE command) and sends it to the host as four UART 8N1 bytes. Each byte uses the same tagged-nibble format the host already sends to the FPGA: tag in the high nibble, payload in the low nibble. The host decodes replies with the same parser it uses for commands. The block sits on the serial clock domain and drives the board TX pin.

---
 rtl/ice_pkg.sv | 37 +++
 rtl/uart_tx_frame.sv | 137 +++++++++++++
 rtl/ice_tx.sv | 84 ++++++++
 tb/tb_ice_tx.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ice_pkg.sv
// Shared definitions for the ICE serial link: FSM states, tag constants and
// the tagged-nibble byte helpers used by both the transmitter and the command decoder.
package ice_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } ice_state_e;

    localparam int          ICE_OVERSAMPLE = 16;
    localparam logic [3:0]  ICE_TAG_ADDR   = 4'd0;
    localparam logic [3:0]  ICE_TAG_DATA   = 4'd4;

    // Pick nibble idx (0 = least significant) out of a 16-bit word.
    function automatic logic [3:0] ice_nibble(input logic [15:0] word, input logic [1:0] idx);
        logic [3:0] nib;
        case (idx)
            2'd0:    nib = word[3:0];
            2'd1:    nib = word[7:4];
            2'd2:    nib = word[11:8];
            2'd3:    nib = word[15:12];
            default: nib = 4'd0;
        endcase
        return nib;
    endfunction

    // Tag in the high nibble (address or data group plus nibble index), payload low.
    function automatic logic [7:0] ice_make_byte(input logic kind, input logic [1:0] idx,
                                                 input logic [3:0] payload);
        logic [3:0] tag;
        tag = (kind ? ICE_TAG_DATA : ICE_TAG_ADDR) | {2'b00, idx};
        return {tag, payload};
    endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// Single-byte 8N1 serializer paced by an oversample strobe. A follow-on byte
// offered while the stop bit ends is chained with no idle gap.
module uart_tx_frame
    import ice_pkg::*;
#(
    parameter int OVERSAMPLE = ICE_OVERSAMPLE
) (
    input  logic       CLK,
    input  logic       I_RESET,
    input  logic       i_baud,
    input  logic       i_load,
    input  logic       i_more,
    input  logic [7:0] i_data,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_tx,
    output logic       o_frame_end
);

    localparam logic [3:0] TICK_MAX = 4'(OVERSAMPLE - 1);

    ice_state_e state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] shreg_q, shreg_d;
    logic       tx_q, tx_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       bit_end;

    assign bit_end     = i_baud && (tick_q == TICK_MAX);
    assign o_frame_end = (state_q == STOP) && bit_end;
    assign o_busy      = busy_q;
    assign o_done      = done_q;
    assign o_tx        = tx_q;

    // Next-state, bit timing and line value for the frame in flight.
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        if ((state_q != IDLE) && i_baud) begin
            tick_d = bit_end ? 4'd0 : (tick_q + 4'd1);
        end else begin
            tick_d = tick_q;
        end

        case (state_q)
            IDLE: begin
                if (i_load) begin
                    state_d = START;
                    tick_d  = 4'd0;
                    bit_d   = 3'd0;
                    shreg_d = i_data;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d = DATA;
                    bit_d   = 3'd0;
                    tx_d    = shreg_q[0];
                end else begin
                    state_d = START;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shreg_d = {1'b0, shreg_q[7:1]};
                        tx_d    = shreg_q[1];
                    end
                end else begin
                    state_d = DATA;
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (i_more) begin
                        state_d = START;
                        bit_d   = 3'd0;
                        shreg_d = i_data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                        tx_d    = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end else begin
                    state_d = STOP;
                end
            end
            default: begin
                state_d = IDLE;
                tick_d  = 4'd0;
                bit_d   = 3'd0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Frame state registers; line idles high.
    always_ff @(posedge CLK) begin
        if (I_RESET) begin
            state_q <= IDLE;
            tick_q  <= 4'd0;
            bit_q   <= 3'd0;
            shreg_q <= 8'd0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: rtl/ice_tx.sv
// ICE reply transmitter: sends a 16-bit word as four tagged-nibble UART bytes,
// least significant nibble first, back to back.
module ice_tx
    import ice_pkg::*;
#(
    parameter int OVERSAMPLE = ICE_OVERSAMPLE
) (
    input  logic        CLK,
    input  logic        I_RESET,
    input  logic        I_BAUD16,
    input  logic        I_SEND,
    input  logic        I_KIND,
    input  logic [15:0] I_WORD,
    output logic        O_BUSY,
    output logic        O_DONE,
    output logic        O_TX
);

    logic [15:0] word_q, word_d;
    logic        kind_q, kind_d;
    logic [1:0]  nib_q, nib_d;
    logic [1:0]  nib_next;
    logic        accept;
    logic        frame_end;
    logic        frame_more;
    logic        frame_busy;
    logic        frame_done;
    logic [7:0]  frame_data;

    // The done cycle still counts as busy for acceptance: a request there is dropped.
    assign accept     = I_SEND && !frame_busy && !frame_done;
    assign nib_next   = nib_q + 2'd1;
    assign frame_more = (nib_q != 2'd3);
    assign frame_data = accept ? ice_make_byte(I_KIND, 2'd0, I_WORD[3:0])
                               : ice_make_byte(kind_q, nib_next, ice_nibble(word_q, nib_next));

    // Word latch and nibble sequencer.
    always_comb begin
        word_d = word_q;
        kind_d = kind_q;
        nib_d  = nib_q;
        if (accept) begin
            word_d = I_WORD;
            kind_d = I_KIND;
            nib_d  = 2'd0;
        end else if (frame_end) begin
            nib_d  = nib_next;
        end else begin
            nib_d  = nib_q;
        end
    end

    // Sequencer registers.
    always_ff @(posedge CLK) begin
        if (I_RESET) begin
            word_q <= 16'd0;
            kind_q <= 1'b0;
            nib_q  <= 2'd0;
        end else begin
            word_q <= word_d;
            kind_q <= kind_d;
            nib_q  <= nib_d;
        end
    end

    uart_tx_frame #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_frame (
        .CLK         (CLK),
        .I_RESET     (I_RESET),
        .i_baud      (I_BAUD16),
        .i_load      (accept),
        .i_more      (frame_more),
        .i_data      (frame_data),
        .o_busy      (frame_busy),
        .o_done      (frame_done),
        .o_tx        (O_TX),
        .o_frame_end (frame_end)
    );

    assign O_BUSY = frame_busy;
    assign O_DONE = frame_done;

endmodule

// File: tb/tb_ice_tx.sv
// Bench for ice_tx: random and directed words, a UART receive monitor with a
// host-side tagged-nibble decoder, and a byte scoreboard.
module tb_ice_tx;

    localparam int OS          = 16;
    localparam int WORD_STROBES = 4 * 10 * OS;

    logic        CLK = 1'b0;
    logic        I_RESET;
    logic        I_BAUD16;
    logic        I_SEND;
    logic        I_KIND;
    logic [15:0] I_WORD;
    logic        O_BUSY;
    logic        O_DONE;
    logic        O_TX;

    ice_tx #(.OVERSAMPLE(OS)) dut (
        .CLK      (CLK),
        .I_RESET  (I_RESET),
        .I_BAUD16 (I_BAUD16),
        .I_SEND   (I_SEND),
        .I_KIND   (I_KIND),
        .I_WORD   (I_WORD),
        .O_BUSY   (O_BUSY),
        .O_DONE   (O_DONE),
        .O_TX     (O_TX)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Reference model state
    logic [7:0] exp_q[$];
    bit         acc_active = 1'b0;
    int         strobe_cnt = 0;
    int         acc_cyc    = 0;
    bit         chk_timing = 1'b0;
    int         done_seen  = 0;
    int         baud_mode  = 0;
    bit         stall      = 1'b0;

    // Receive monitor state and host-side decoder registers
    bit         rx = 1'b0;
    int         n_rx = 0;
    logic       val;
    bit         have_val = 1'b0;
    bit         glitch = 1'b0;
    logic [9:0] bits;
    bit         rst_prev = 1'b0;
    logic [15:0] data_reg = 16'h0;
    logic [15:0] addr_reg = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    initial begin
        I_BAUD16 = 1'b0;
        forever begin
            @(posedge CLK);
            #1;
            if (stall)               I_BAUD16 = 1'b0;
            else if (baud_mode == 0) I_BAUD16 = (cyc % 2 == 1);
            else                     I_BAUD16 = ($urandom_range(0, 2) == 0);
        end
    end

    task automatic handle_byte(input logic [9:0] fr);
        logic [7:0] b;
        b = fr[8:1];
        check("stop_bit", fr[9], 1'b1);
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_byte: got %0h, expected no byte", b);
        end else begin
            check("byte", b, exp_q.pop_front());
        end
        if (b[6]) data_reg[4*b[5:4] +: 4] = b[3:0];
        else      addr_reg[4*b[5:4] +: 4] = b[3:0];
    endtask

    always @(negedge CLK) begin
        if (rst_prev) begin
            check("rst_tx",   O_TX,   1'b1);
            check("rst_busy", O_BUSY, 1'b0);
            check("rst_done", O_DONE, 1'b0);
        end
        if (I_RESET === 1'b1) begin
            rst_prev   = 1'b1;
            rx         = 1'b0;
            acc_active = 1'b0;
            exp_q.delete();
        end else begin
            bit exp_done;
            rst_prev = 1'b0;
            exp_done = acc_active && (strobe_cnt == WORD_STROBES);
            check("busy", O_BUSY, acc_active && (strobe_cnt < WORD_STROBES));
            check("done", O_DONE, exp_done);
            if (exp_done) begin
                if (chk_timing) check("done_cycle", cyc - acc_cyc, 1281);
                acc_active = 1'b0;
                done_seen++;
            end
            if (acc_active && I_BAUD16) strobe_cnt++;

            if (!rx && O_TX === 1'b0) begin
                rx       = 1'b1;
                n_rx     = 0;
                have_val = 1'b0;
                glitch   = 1'b0;
            end
            if (rx) begin
                if (!have_val) begin
                    val      = O_TX;
                    have_val = 1'b1;
                end else if (O_TX !== val) begin
                    glitch = 1'b1;
                end
                if (I_BAUD16) begin
                    n_rx++;
                    if (n_rx % OS == 0) begin
                        check("bit_stable", glitch, 1'b0);
                        bits[n_rx/OS - 1] = val;
                        have_val = 1'b0;
                        glitch   = 1'b0;
                        if (n_rx == 10 * OS) begin
                            rx = 1'b0;
                            handle_byte(bits);
                        end
                    end
                end
            end
        end
    end

    task automatic send(input logic [15:0] w, input logic k);
        @(posedge CLK);
        #2;
        while (baud_mode == 0 && I_BAUD16 == 1'b0) begin
            @(posedge CLK);
            #2;
        end
        I_SEND = 1'b1;
        I_WORD = w;
        I_KIND = k;
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, k, 2'(i), w[4*i +: 4]});
        acc_cyc = cyc;
        @(posedge CLK);
        #2;
        I_SEND     = 1'b0;
        strobe_cnt = 0;
        acc_active = 1'b1;
    endtask

    task automatic wait_idle(input int budget);
        int c;
        c = 0;
        while (acc_active && c < budget) begin
            @(negedge CLK);
            c++;
        end
        if (acc_active) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: got busy after %0d cycles, expected idle", budget);
            acc_active = 1'b0;
        end
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0;
        logic tx_hold;
        logic [15:0] w;
        logic k;
        I_RESET = 1'b1;
        I_SEND  = 1'b0;
        I_KIND  = 1'b0;
        I_WORD  = 16'h0;
        repeat (3) @(posedge CLK);
        #2 I_RESET = 1'b0;

        repeat (100) @(negedge CLK);
        check("idle_tx", O_TX, 1'b1);
        check("idle_busy", O_BUSY, 1'b0);

        // Data word with strobe every second cycle
        baud_mode  = 0;
        chk_timing = 1'b1;
        d0 = done_seen;
        send(16'h1234, 1'b1);
        wait_idle(5000);
        check("data_1234", data_reg, 16'h1234);
        check("done_count_1234", done_seen - d0, 1);

        // Address word with a 50-cycle strobe stall mid-bit
        chk_timing = 1'b0;
        send(16'hBEEF, 1'b0);
        repeat (301) @(negedge CLK);
        tx_hold = O_TX;
        stall = 1'b1;
        repeat (50) @(negedge CLK);
        check("stall_tx", O_TX, tx_hold);
        stall = 1'b0;
        wait_idle(5000);
        check("addr_beef", addr_reg, 16'hBEEF);

        // Request during byte 1 is ignored, as is one in the done cycle
        chk_timing = 1'b1;
        d0 = done_seen;
        send(16'h1234, 1'b1);
        repeat (400) @(negedge CLK);
        I_SEND = 1'b1;
        I_WORD = 16'hFFFF;
        @(posedge CLK);
        #2 I_SEND = 1'b0;
        for (int c = 0; c < 5000 && O_DONE !== 1'b1; c++) @(negedge CLK);
        I_SEND = 1'b1;
        I_WORD = 16'hFFFF;
        @(posedge CLK);
        #2 I_SEND = 1'b0;
        repeat (60) @(negedge CLK);
        check("ignored_busy", O_BUSY, 1'b0);
        check("ignored_done_count", done_seen - d0, 1);
        check("ignored_data", data_reg, 16'h1234);

        // Reset mid-frame abandons the word
        chk_timing = 1'b0;
        d0 = done_seen;
        send(16'h5A5A, 1'b0);
        repeat (500) @(negedge CLK);
        check("pre_reset_busy", O_BUSY, 1'b1);
        @(posedge CLK);
        #2 I_RESET = 1'b1;
        @(posedge CLK);
        #2 I_RESET = 1'b0;
        repeat (50) @(negedge CLK);
        check("reset_no_done", done_seen - d0, 0);

        // Loopback through the host decoder
        chk_timing = 1'b1;
        send(16'hA5C3, 1'b1);
        wait_idle(5000);
        check("loopback_a5c3", data_reg, 16'hA5C3);

        // Random words with irregular strobes
        baud_mode  = 1;
        chk_timing = 1'b0;
        for (int i = 0; i < 4; i++) begin
            w = 16'($urandom);
            k = 1'($urandom);
            send(w, k);
            wait_idle(20000);
            check("random_word", k ? data_reg : addr_reg, w);
        end

        check("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
